// File: rtl/scan_seq_pkg.sv
// Shared definitions for the scan-chain sequencer: command opcodes, FSM
// state encodings, the signature CRC polynomial and width helpers.
package scan_seq_pkg;

  typedef enum logic [1:0] {
    OP_SHIFT = 2'b00,
    OP_RUN   = 2'b01,
    OP_CLR   = 2'b10,
    OP_SIG   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_RUN   = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  localparam logic [7:0] CRC_POLY = 8'h07;

  // Width needed to hold a chain position 0..chain_len.
  function automatic int ptr_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

  // Width needed to hold an index 0..n-1 (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_seq_crc8.sv
// Bit-serial CRC-8 (poly 0x07) over captured scan bits. Only instantiated
// when SCAN_SEQ_SIGNATURE_EN is defined.
module scan_seq_crc8
  import scan_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic       fb;

  // Next CRC value for one incoming bit, MSB feedback form.
  always_comb begin
    fb    = crc_q[7] ^ bit_i;
    crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  end

  // Signature register; clear wins over an update in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      crc_q <= 8'h00;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/scan_sequencer.sv
// Scan-chain sequencer: turns host word commands into bit-serial scan
// shifts and bounded processor run bursts, returning one response word
// per command. Optional capture signature: define SCAN_SEQ_SIGNATURE_EN.
//
//   state    | meaning
//   ST_IDLE  | waiting for a command, cmd_ready high
//   ST_SHIFT | shifting k bits MSB-first, capturing scan_in
//   ST_RUN   | proc_en_out high, counting down the burst
//   ST_RESP  | rsp_valid high until the host takes the word
module scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter  int CHAIN_LEN = 168,
  parameter  int WORD_W    = 8,
  parameter  int RUN_W     = 8,
  localparam int PTR_W     = ptr_width(CHAIN_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WORD_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic              scan_enable_out,
  output logic              scan_out,
  input  logic              scan_in,
  output logic              proc_en_out,
  output logic [PTR_W-1:0]  bit_ptr
);

  localparam int IDX_W = idx_width(WORD_W);

  state_e              state_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [WORD_W-1:0]   rsp_data_q;
  logic                scan_en_q;
  logic                scan_out_q;
  logic                proc_en_q;
  logic [PTR_W-1:0]    bit_ptr_q;
  logic [WORD_W-1:0]   sh_q;
  logic [WORD_W-1:0]   cap_q;
  logic [IDX_W-1:0]    idx_q;
  logic [RUN_W-1:0]    run_q;

  logic [PTR_W-1:0]    bit_ptr_d;
  logic [WORD_W-1:0]   cap_d;
  logic [IDX_W-1:0]    k_m1_d;
  logic [RUN_W-1:0]    run_n;
  int                  rem;
  logic [7:0]          sig;
  logic [WORD_W-1:0]   sig_word;

  assign run_n = cmd_data[RUN_W-1:0];

  // Shift length for the next SHIFT (stored as k-1), next capture word and
  // next chain position; the position wraps to 0 on the last chain bit.
  always_comb begin
    rem       = CHAIN_LEN - int'(bit_ptr_q);
    k_m1_d    = (rem < WORD_W) ? IDX_W'(rem - 1) : IDX_W'(WORD_W - 1);
    cap_d     = (cap_q << 1) | WORD_W'(scan_in);
    bit_ptr_d = (bit_ptr_q == PTR_W'(CHAIN_LEN - 1)) ? '0 : bit_ptr_q + PTR_W'(1);
  end

`ifdef SCAN_SEQ_SIGNATURE_EN
  logic crc_clr;
  logic crc_en;

  assign crc_clr = (state_q == ST_IDLE) && cmd_valid && (cmd_op == OP_CLR);
  assign crc_en  = (state_q == ST_SHIFT);

  scan_seq_crc8 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .bit_i (scan_in),
    .crc_o (sig)
  );
`else
  assign sig = 8'h00;
`endif

  // Zero-extend (or truncate for narrow hosts) the signature to a word.
  always_comb begin
    sig_word = '0;
    for (int i = 0; i < WORD_W && i < 8; i++) begin
      sig_word[i] = sig[i];
    end
  end

  // Main sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      scan_en_q   <= 1'b0;
      scan_out_q  <= 1'b0;
      proc_en_q   <= 1'b0;
      bit_ptr_q   <= '0;
      sh_q        <= '0;
      cap_q       <= '0;
      idx_q       <= '0;
      run_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            sh_q        <= cmd_data;
            case (cmd_op)
              OP_SHIFT: begin
                cap_q      <= '0;
                idx_q      <= k_m1_d;
                scan_out_q <= cmd_data[k_m1_d];
                scan_en_q  <= 1'b1;
                state_q    <= ST_SHIFT;
              end
              OP_RUN: begin
                if (run_n == '0) begin
                  rsp_data_q  <= '0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
                end else begin
                  run_q     <= run_n - RUN_W'(1);
                  proc_en_q <= 1'b1;
                  state_q   <= ST_RUN;
                end
              end
              OP_CLR: begin
                bit_ptr_q   <= '0;
                rsp_data_q  <= '0;
                rsp_valid_q <= 1'b1;
                state_q     <= ST_RESP;
              end
              default: begin
                rsp_data_q  <= sig_word;
                rsp_valid_q <= 1'b1;
                state_q     <= ST_RESP;
              end
            endcase
          end
        end
        ST_SHIFT: begin
          cap_q     <= cap_d;
          bit_ptr_q <= bit_ptr_d;
          if (idx_q == '0) begin
            scan_en_q   <= 1'b0;
            scan_out_q  <= 1'b0;
            rsp_data_q  <= cap_d;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            idx_q      <= idx_q - IDX_W'(1);
            scan_out_q <= sh_q[idx_q - IDX_W'(1)];
          end
        end
        ST_RUN: begin
          if (run_q == '0) begin
            proc_en_q   <= 1'b0;
            rsp_data_q  <= WORD_W'(sh_q[RUN_W-1:0]);
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            run_q <= run_q - RUN_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          scan_en_q   <= 1'b0;
          proc_en_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign scan_enable_out = scan_en_q;
  assign scan_out        = scan_out_q;
  assign proc_en_out     = proc_en_q;
  assign bit_ptr         = bit_ptr_q;

endmodule
